// File: rtl/arb_pkg.sv
// Shared definitions for the memory read-burst arbiter: FSM encoding and
// default geometry.
package arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted req at or above rr_ptr,
// wrapping modulo N_REQ; one-hot result, all zero when no request.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner
);

  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter granting whole read bursts (1..4 words) to one of
// N_REQ requesters; read data returns one cycle after each memory read.
module mem_read_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*2-1:0]    req_len,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic                  mem_r_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                rsp_last_q, rsp_last_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [1:0]          beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]    winner;
  logic [PTR_W-1:0]    win_idx, gnt_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (winner)
  );

  // One-hot to index for both the fresh winner and the held grant.
  always_comb begin
    win_idx = '0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
      if (gnt_q[i])  gnt_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_cnt_d  = addr_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d      = winner;
          addr_cnt_d = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          beat_cnt_d = req_len[int'(win_idx)*2 +: 2];
          state_d    = BURST;
        end
      end
      BURST: begin
        // The read issued this cycle returns next cycle as a response.
        rsp_valid_d = gnt_q;
        rsp_last_d  = (beat_cnt_q == 2'd0);
        addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
        if (beat_cnt_q == 2'd0) begin
          state_d = DRAIN;
        end else begin
          beat_cnt_d = beat_cnt_q - 2'd1;
        end
      end
      DRAIN: begin
        gnt_d    = '0;
        rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        state_d  = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      addr_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      addr_cnt_q  <= addr_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = mem_rdata;
  assign busy      = (state_q != IDLE);
  assign mem_r_en  = (state_q == BURST);
  assign mem_addr  = (state_q == BURST) ? addr_cnt_q : '0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: single burst, simultaneous requests,
// address wrap, fairness, reset mid-burst and request drop.
module tb_mem_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*2-1:0]  req_len;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            busy;
  logic            mem_r_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_read_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .mem_r_en  (mem_r_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: data is A5 in the high byte and the address in the low byte.
  always @(posedge clk) if (mem_r_en) mem_rdata <= {8'hA5, mem_addr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Follows a burst starting right after its grant edge, through DRAIN and
  // the following IDLE cycle. At beat drop_at, req is dropped and the
  // requester's addr/len are scrambled.
  task automatic expect_burst(input int who, input logic [7:0] addr,
                              input int len, input int drop_at);
    logic [3:0] oh;
    logic [7:0] a;
    oh = 4'b0001 << who;
    for (int c = 0; c <= len; c++) begin
      if (c == drop_at) begin
        req = '0;
        req_addr[who*AW +: AW] = 8'h77;
        req_len[who*2 +: 2]    = 2'd0;
      end
      a = addr + 8'(c);
      n_cmp++;
      if (gnt !== oh || mem_r_en !== 1'b1 || mem_addr !== a || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_beat who=%0d beat=%0d: gnt=%b en=%b addr=%h busy=%b, want gnt=%b en=1 addr=%h busy=1",
                 who, c, gnt, mem_r_en, mem_addr, busy, oh, a);
      end
      n_cmp++;
      if (rsp_valid !== ((c == 0) ? 4'b0000 : oh) || rsp_last !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_rsp who=%0d beat=%0d: rsp_valid=%b last=%b, want rsp_valid=%b last=0",
                 who, c, rsp_valid, rsp_last, (c == 0) ? 4'b0000 : oh);
      end
      if (c > 0) begin
        n_cmp++;
        if (rsp_data !== {8'hA5, a - 8'd1}) begin
          n_fail++;
          $display("FAIL burst_data who=%0d beat=%0d: rsp_data=%h, want %h",
                   who, c, rsp_data, {8'hA5, a - 8'd1});
        end
      end
      tick();
    end
    a = addr + 8'(len);
    n_cmp++;
    if (gnt !== oh || mem_r_en !== 1'b0 || busy !== 1'b1 || rsp_valid !== oh ||
        rsp_last !== 1'b1 || rsp_data !== {8'hA5, a}) begin
      n_fail++;
      $display("FAIL drain who=%0d: gnt=%b en=%b busy=%b rsp_valid=%b last=%b data=%h, want gnt=%b en=0 busy=1 rsp_valid=%b last=1 data=%h",
               who, gnt, mem_r_en, busy, rsp_valid, rsp_last, rsp_data, oh, oh, {8'hA5, a});
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || rsp_valid !== 4'b0000 || mem_r_en !== 1'b0 || rsp_last !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bubble who=%0d: gnt=%b busy=%b rsp_valid=%b en=%b last=%b, want all 0",
               who, gnt, busy, rsp_valid, mem_r_en, rsp_last);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req_len = '0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0 || rsp_valid !== 4'b0 || rsp_last !== 1'b0 || busy !== 1'b0 ||
        mem_r_en !== 1'b0 || mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b rsp_valid=%b last=%b busy=%b en=%b addr=%h, want all 0",
               gnt, rsp_valid, rsp_last, busy, mem_r_en, mem_addr);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || mem_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b busy=%b en=%b, want 0 0 0", gnt, busy, mem_r_en);
    end
  endtask

  task automatic test_single;
    req_addr[0 +: AW] = 8'h10;
    req_len[0 +: 2]   = 2'd3;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    expect_burst(0, 8'h10, 3, -1);
  endtask

  task automatic test_simultaneous;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = 8'h20 + 8'(16 * i);
      req_len[i*2 +: 2]    = 2'd0;
    end
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      tick();
      if (k == N - 1) req = 4'b0000;
      expect_burst(k, 8'h20 + 8'(16 * k), 0, -1);
    end
  endtask

  task automatic test_wrap;
    req_addr[2*AW +: AW] = 8'hFE;
    req_len[2*2 +: 2]    = 2'd3;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    expect_burst(2, 8'hFE, 3, -1);
  endtask

  task automatic test_fairness;
    int w;
    apply_reset();
    req_addr[0 +: AW]    = 8'h60;
    req_addr[2*AW +: AW] = 8'h80;
    req_len[0 +: 2]      = 2'd1;
    req_len[2*2 +: 2]    = 2'd1;
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      w = (k % 2 == 0) ? 0 : 2;
      if (k == 3) req = 4'b0000;
      expect_burst(w, (w == 0) ? 8'h60 : 8'h80, 1, -1);
    end
  endtask

  task automatic test_reset_mid_burst;
    req_addr[0 +: AW] = 8'h40;
    req_len[0 +: 2]   = 2'd3;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    n_cmp++;
    if (mem_addr !== 8'h41 || rsp_valid !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_burst_pre: addr=%h rsp_valid=%b, want 41 0001", mem_addr, rsp_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0 || rsp_valid !== 4'b0 || rsp_last !== 1'b0 || busy !== 1'b0 ||
        mem_r_en !== 1'b0 || mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_burst_reset: gnt=%b rsp_valid=%b last=%b busy=%b en=%b addr=%h, want all 0",
               gnt, rsp_valid, rsp_last, busy, mem_r_en, mem_addr);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_release: rsp_valid=%b busy=%b, want 0000 0", rsp_valid, busy);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || mem_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_cycle: rsp_valid=%b busy=%b en=%b, want 0000 0 0", rsp_valid, busy, mem_r_en);
    end
    // rr_ptr back at 0: with 1010 requested, requester 1 must win (3 would if the pointer survived).
    req_addr[1*AW +: AW] = 8'h90;
    req_addr[3*AW +: AW] = 8'hB0;
    req_len[1*2 +: 2]    = 2'd1;
    req_len[3*2 +: 2]    = 2'd0;
    req = 4'b1010;
    tick();
    req = 4'b0000;
    expect_burst(1, 8'h90, 1, -1);
  endtask

  task automatic test_req_drop;
    req_addr[1*AW +: AW] = 8'hC0;
    req_len[1*2 +: 2]    = 2'd2;
    req = 4'b0010;
    tick();
    expect_burst(1, 8'hC0, 2, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_wrap();
    test_fairness();
    test_reset_mid_burst();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
